// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with configurable data width, parity, stop bits and a valid/ready output.
//   clk, rst         : system clock, synchronous active-high reset
//   tick             : baud enable, OVERSAMPLE pulses per bit
//   rx               : asynchronous serial line, idle high
//   rx_data          : received word, LSB first on the line
//   rx_valid/rx_ready: output handshake, word held until accepted
//   frame_err        : a stop bit of this word sampled low
//   parity_err       : parity mismatch for this word
//   overrun          : sticky, a word was dropped while rx_valid was pending
//   busy             : receiver is inside a frame
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic rx_s, rx_prev, ferr, perr, mid, centre, last_data, last_stop, done, load;
  assign rx_s      = sync[SYNC_STAGES-1];
  assign mid       = tick_cnt == TW'(OVERSAMPLE / 2 - 1);
  assign centre    = tick_cnt == TW'(OVERSAMPLE - 1);
  assign last_data = bit_cnt == BW'(DATA_BITS - 1);
  assign last_stop = bit_cnt == BW'(STOP_BITS - 1);
  assign done      = tick && state == STOP && centre && last_stop;
  assign load      = done && (!rx_valid || rx_ready);
  assign busy      = state != IDLE;
  always_ff @(posedge clk)
    if (rst) sync <= '1;
    else sync <= {sync[SYNC_STAGES-2:0], rx};
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      ferr       <= 1'b0;
      perr       <= 1'b0;
      rx_prev    <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (tick) begin
        // rx_prev makes IDLE wait for a real falling edge, so a line held low after a bad stop bit is not re-read as a start bit
        rx_prev  <= rx_s;
        tick_cnt <= tick_cnt + 1'b1;
        case (state)
          IDLE: begin
            tick_cnt <= '0;
            if (!rx_s && rx_prev) state <= START;
          end
          START:
            if (mid) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              ferr     <= 1'b0;
              perr     <= 1'b0;
              state    <= rx_s ? IDLE : DATA;
            end
          DATA:
            if (centre) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_cnt  <= last_data ? '0 : bit_cnt + 1'b1;
              if (last_data) state <= PARITY_EN != 0 ? PARITY : STOP;
            end
          PARITY:
            if (centre) begin
              tick_cnt <= '0;
              perr     <= (^shreg ^ rx_s) != (PARITY_ODD != 0);
              state    <= STOP;
            end
          STOP:
            if (centre) begin
              tick_cnt <= '0;
              ferr     <= ferr | !rx_s;
              bit_cnt  <= last_stop ? '0 : bit_cnt + 1'b1;
              if (last_stop) state <= IDLE;
            end
          default: state <= IDLE;
        endcase
      end
      // a completion wins over a plain accept; a blocked completion keeps the old word and flags overrun
      if (load) begin
        rx_data    <= shreg;
        frame_err  <= ferr | !rx_s;
        parity_err <= perr;
        rx_valid   <= 1'b1;
        if (rx_valid) overrun <= 1'b0;
      end else if (done) begin
        overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for two receiver configurations (8N1/16x and 7O2/8x with 3 sync stages).
module tb_uart_rx_param;
  localparam int TDIV = 4;
  typedef struct packed {logic [8:0] d; logic fe; logic pe;} exp_t;
  logic clk = 1'b0, rst = 1'b1, tick;
  logic [1:0] rx = 2'b11, rdy = 2'b11, fix_rdy = 2'b11;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [1:0] vld, fe, pe, ov, bsy;
  logic [1:0] pv = 2'b00, pr = 2'b00;
  logic [8:0] pd [2];
  int tcnt = 0, checks = 0, failures = 0;
  bit rand_rdy = 1'b0;
  exp_t q0[$], q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= (tcnt == TDIV - 1) ? 0 : tcnt + 1;
  assign tick = tcnt == 0;
  uart_rx_param u0 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx[0]), .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]), .busy(bsy[0]));
  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .SYNC_STAGES(3)) u1 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx[1]), .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]), .busy(bsy[1]));
  function automatic int os(input int i); return i == 1 ? 8 : 16; endfunction
  function automatic int dbits(input int i); return i == 1 ? 7 : 8; endfunction
  function automatic int stops(input int i); return i == 1 ? 2 : 1; endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask
  always begin
    @(posedge clk);
    #1;
    rdy = rand_rdy ? 2'($urandom) : fix_rdy;
  end
  always begin
    logic [8:0] dd;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      dd = i == 1 ? {2'b00, d1} : {1'b0, d0};
      if (!rst) begin
        if (pv[i] && !pr[i]) begin
          chk($sformatf("hold_valid%0d", i), 32'(vld[i]), 32'd1);
          chk($sformatf("hold_data%0d", i), 32'(dd), 32'(pd[i]));
        end
        if (pv[i] && pr[i]) chk($sformatf("drop_after_accept%0d", i), 32'(vld[i]), 32'd0);
        if (vld[i] && rdy[i]) begin
          if ((i == 1 ? q1.size() : q0.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word%0d actual=%0h expected=none", i, dd);
          end else begin
            if (i == 1) e = q1.pop_front();
            else e = q0.pop_front();
            chk($sformatf("data%0d", i), 32'(dd), 32'(e.d));
            chk($sformatf("frame_err%0d", i), 32'(fe[i]), 32'(e.fe));
            chk($sformatf("parity_err%0d", i), 32'(pe[i]), 32'(e.pe));
          end
        end
      end
      pv[i] = vld[i] & !rst;
      pr[i] = rdy[i];
      pd[i] = dd;
    end
  end
  task automatic bit_out(input int i, input logic v);
    rx[i] = v;
    repeat (os(i) * TDIV) @(posedge clk);
    #1;
  endtask
  task automatic idle(input int i, input int n);
    for (int k = 0; k < n; k++) bit_out(i, 1'b1);
  endtask
  task automatic send(input int i, input logic [8:0] data, input bit bad_par, input logic [1:0] stop_low, input bit expect_out);
    exp_t e;
    logic p;
    p = ^data ^ (i == 1) ^ bad_par;
    e.d  = data;
    e.pe = (i == 1) && bad_par;
    e.fe = |(stop_low & (i == 1 ? 2'b11 : 2'b01));
    if (expect_out) begin
      if (i == 1) q1.push_back(e);
      else q0.push_back(e);
    end
    bit_out(i, 1'b0);
    for (int b = 0; b < dbits(i); b++) bit_out(i, data[b]);
    if (i == 1) bit_out(i, p);
    for (int s = 0; s < stops(i); s++) bit_out(i, !stop_low[s]);
    rx[i] = 1'b1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", 32'(vld[i]), 32'd0);
      chk("rst_busy", 32'(bsy[i]), 32'd0);
      chk("rst_flags", 32'({fe[i], pe[i], ov[i]}), 32'd0);
    end
    chk("rst_data0", 32'(d0), 32'd0);
    chk("rst_data1", 32'(d1), 32'd0);
    @(posedge clk);
    #1;
    send(0, 9'hA5, 1'b0, 2'b00, 1'b1);
    idle(0, 2);
    rx[0] = 1'b0;
    repeat (4 * TDIV) @(posedge clk);
    #1;
    chk("glitch_busy_rise", 32'(bsy[0]), 32'd1);
    idle(0, 1);
    chk("glitch_busy_fall", 32'(bsy[0]), 32'd0);
    chk("glitch_no_valid", 32'(vld[0]), 32'd0);
    send(1, 9'h03, 1'b0, 2'b00, 1'b1);
    idle(1, 1);
    send(1, 9'h03, 1'b1, 2'b00, 1'b1);
    idle(1, 1);
    send(0, 9'h55, 1'b0, 2'b01, 1'b1);
    idle(0, 2);
    send(0, 9'h3C, 1'b0, 2'b00, 1'b1);
    idle(0, 1);
    send(1, 9'h55, 1'b0, 2'b10, 1'b1);
    idle(1, 2);
    send(1, 9'h2A, 1'b0, 2'b00, 1'b1);
    idle(1, 1);
    fix_rdy[0] = 1'b0;
    idle(0, 1);
    send(0, 9'h11, 1'b0, 2'b00, 1'b1);
    idle(0, 1);
    send(0, 9'h22, 1'b0, 2'b00, 1'b0);
    idle(0, 1);
    chk("overrun_set", 32'(ov[0]), 32'd1);
    chk("overrun_keep_data", 32'(d0), 32'h11);
    chk("overrun_keep_valid", 32'(vld[0]), 32'd1);
    fix_rdy[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("overrun_clear", 32'(ov[0]), 32'd0);
    chk("overrun_valid_drop", 32'(vld[0]), 32'd0);
    bit_out(1, 1'b0);
    bit_out(1, 1'b1);
    bit_out(1, 1'b0);
    rst = 1'b1;
    rx[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", 32'(bsy[1]), 32'd0);
    chk("abort_valid", 32'(vld[1]), 32'd0);
    idle(1, 2);
    send(1, 9'h7F, 1'b0, 2'b00, 1'b1);
    idle(1, 1);
    rand_rdy = 1'b1;
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 2; i++) begin
        send(i, 9'($urandom_range(0, i == 1 ? 127 : 255)), $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00, 1'b1);
        idle(i, $urandom_range(1, 3));
      end
    rand_rdy = 1'b0;
    for (int t = 0; t < 2000 && (q0.size() + q1.size()) != 0; t++) @(posedge clk);
    @(negedge clk);
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
